// File: rtl/exec_complete_arbiter.sv
// Round-robin completion arbiter: picks one of three execution units per cycle
// and holds its result in a single-entry output slot that feeds the ROB/CDB.
module exec_complete_arbiter #(
  parameter int ROBsize    = 16,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [2:0]            unitValid_i,
  input  logic [63:0]           unit0Val_i,
  input  logic [63:0]           unit1Val_i,
  input  logic [63:0]           unit2Val_i,
  input  logic [ROBsizeLog-1:0] unit0Tag_i,
  input  logic [ROBsizeLog-1:0] unit1Tag_i,
  input  logic [ROBsizeLog-1:0] unit2Tag_i,
  input  logic [9:0]            unit0Commands_i,
  input  logic [9:0]            unit1Commands_i,
  input  logic [9:0]            unit2Commands_i,
  input  logic [3:0]            unit0Flags_i,
  input  logic [3:0]            unit1Flags_i,
  input  logic [3:0]            unit2Flags_i,
  output logic [2:0]            canGo_o,
  input  logic                  robReady_i,
  input  logic                  flush_i,
  output logic                  cdbValid_o,
  output logic [63:0]           cdbVal_o,
  output logic [ROBsizeLog-1:0] cdbTag_o,
  output logic [9:0]            cdbCommands_o,
  output logic [3:0]            cdbFlags_o,
  output logic [1:0]            cdbUnit_o
);

  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e                 state_q, state_d;
  logic [1:0]            last_q, last_d;
  logic [63:0]           val_q, val_d;
  logic [ROBsizeLog-1:0] tag_q, tag_d;
  logic [9:0]            cmd_q, cmd_d;
  logic [3:0]            flg_q, flg_d;
  logic [1:0]            unit_q, unit_d;

  logic       load_ok;
  logic       gnt_found;
  logic [1:0] gnt_idx;
  logic [1:0] start;
  logic [1:0] cand;

  // Search begins just after the last grant; an illegal last value of 3 acts as 2.
  always_comb begin
    start     = (last_q == 2'd0) ? 2'd1 : (last_q == 2'd1) ? 2'd2 : 2'd0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = 2'((32'(start) + k) % 3);
      if (!gnt_found && unitValid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    val_d    = val_q;
    tag_d    = tag_q;
    cmd_d    = cmd_q;
    flg_d    = flg_q;
    unit_d   = unit_q;
    canGo_o  = '0;
    load_ok  = !reset_i && !flush_i && ((state_q == EMPTY) || robReady_i);

    if (flush_i) begin
      state_d = EMPTY;
    end else if (load_ok && gnt_found) begin
      canGo_o[gnt_idx] = 1'b1;
      state_d = FULL;
      last_d  = gnt_idx;
      unit_d  = gnt_idx;
      case (gnt_idx)
        2'd0: begin
          val_d = unit0Val_i; tag_d = unit0Tag_i; cmd_d = unit0Commands_i; flg_d = unit0Flags_i;
        end
        2'd1: begin
          val_d = unit1Val_i; tag_d = unit1Tag_i; cmd_d = unit1Commands_i; flg_d = unit1Flags_i;
        end
        default: begin
          val_d = unit2Val_i; tag_d = unit2Tag_i; cmd_d = unit2Commands_i; flg_d = unit2Flags_i;
        end
      endcase
    end else if ((state_q == FULL) && robReady_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      last_q  <= 2'd2;
      val_q   <= '0;
      tag_q   <= '0;
      cmd_q   <= '0;
      flg_q   <= '0;
      unit_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      val_q   <= val_d;
      tag_q   <= tag_d;
      cmd_q   <= cmd_d;
      flg_q   <= flg_d;
      unit_q  <= unit_d;
    end
  end

  assign cdbValid_o    = (state_q == FULL);
  assign cdbVal_o      = val_q;
  assign cdbTag_o      = tag_q;
  assign cdbCommands_o = cmd_q;
  assign cdbFlags_o    = flg_q;
  assign cdbUnit_o     = unit_q;

endmodule

// File: tb/tb_exec_complete_arbiter.sv
// Self-checking bench for exec_complete_arbiter: constant vector table, directed
// corner sequences and a randomized run against a behavioural slot/arbiter model.
module tb_exec_complete_arbiter;

  localparam int RS = 16;
  localparam int TW = $clog2(RS + 1);

  logic          clk = 1'b0;
  logic          reset, robReady, flush;
  logic [2:0]    uvalid;
  logic [63:0]   uval [3];
  logic [TW-1:0] utag [3];
  logic [9:0]    ucmd [3];
  logic [3:0]    uflg [3];
  logic [2:0]    canGo;
  logic          cdbValid;
  logic [63:0]   cdbVal;
  logic [TW-1:0] cdbTag;
  logic [9:0]    cdbCmd;
  logic [3:0]    cdbFlg;
  logic [1:0]    cdbUnit;

  always #5 clk = ~clk;

  exec_complete_arbiter #(.ROBsize(RS), .ROBsizeLog(TW)) dut (
    .clk_i(clk), .reset_i(reset), .unitValid_i(uvalid),
    .unit0Val_i(uval[0]), .unit1Val_i(uval[1]), .unit2Val_i(uval[2]),
    .unit0Tag_i(utag[0]), .unit1Tag_i(utag[1]), .unit2Tag_i(utag[2]),
    .unit0Commands_i(ucmd[0]), .unit1Commands_i(ucmd[1]), .unit2Commands_i(ucmd[2]),
    .unit0Flags_i(uflg[0]), .unit1Flags_i(uflg[1]), .unit2Flags_i(uflg[2]),
    .canGo_o(canGo), .robReady_i(robReady), .flush_i(flush),
    .cdbValid_o(cdbValid), .cdbVal_o(cdbVal), .cdbTag_o(cdbTag),
    .cdbCommands_o(cdbCmd), .cdbFlags_o(cdbFlg), .cdbUnit_o(cdbUnit)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the slot is either holding a result or not; priority rotates
  // starting from the unit after the one served last.
  bit            m_v;
  logic [63:0]   m_val;
  logic [TW-1:0] m_tag;
  logic [9:0]    m_cmd;
  logic [3:0]    m_flg;
  int            m_unit;
  int            m_last;

  function automatic int mgrant();
    if (reset || flush || (m_v && !robReady)) return -1;
    for (int k = 1; k <= 3; k++) begin
      int u = (m_last + k) % 3;
      if (uvalid[u]) return u;
    end
    return -1;
  endfunction

  // Inputs are applied just after a rising edge; canGo is sampled at the falling
  // edge, registered outputs just after the next rising edge.
  task automatic mstep(input string nm, output logic [2:0] cg);
    int g;
    logic [2:0] exp_cg;
    @(negedge clk);
    g = mgrant();
    exp_cg = (g < 0) ? 3'b000 : (3'b001 << g);
    cg = canGo;
    chk({nm, ".canGo"}, 64'(canGo), 64'(exp_cg));
    @(posedge clk);
    if (reset) begin
      m_v = 0; m_val = '0; m_tag = '0; m_cmd = '0; m_flg = '0; m_unit = 0; m_last = 2;
    end else if (flush) begin
      m_v = 0;
    end else if (g >= 0) begin
      m_v = 1; m_val = uval[g]; m_tag = utag[g]; m_cmd = ucmd[g]; m_flg = uflg[g];
      m_unit = g; m_last = g;
    end else if (m_v && robReady) begin
      m_v = 0;
    end
    #1;
    chk({nm, ".cdbValid"}, 64'(cdbValid), 64'(m_v));
    chk({nm, ".cdbVal"}, cdbVal, m_val);
    chk({nm, ".cdbTag"}, 64'(cdbTag), 64'(m_tag));
    chk({nm, ".cdbCmd"}, 64'(cdbCmd), 64'(m_cmd));
    chk({nm, ".cdbFlags"}, 64'(cdbFlg), 64'(m_flg));
    chk({nm, ".cdbUnit"}, 64'(cdbUnit), 64'(m_unit));
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] uv;
    logic       rr;
    logic       fl;
    logic [2:0] exp_cg;
    logic       exp_v;
    logic [1:0] exp_unit;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [2:0] cg;
    bit pend [3];

    vecs[0]  = '{1'b1, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0};
    vecs[2]  = '{1'b0, 3'b111, 1'b1, 1'b0, 3'b010, 1'b1, 2'd1};
    vecs[3]  = '{1'b0, 3'b111, 1'b1, 1'b0, 3'b100, 1'b1, 2'd2};
    vecs[4]  = '{1'b0, 3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0};
    vecs[5]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0};
    vecs[6]  = '{1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0};
    vecs[7]  = '{1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 3'b010, 1'b1, 1'b1, 3'b000, 1'b0, 2'd1};
    vecs[9]  = '{1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 2'd1};
    vecs[11] = '{1'b0, 3'b100, 1'b1, 1'b0, 3'b100, 1'b1, 2'd2};
    vecs[12] = '{1'b1, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 3'b011, 1'b1, 1'b0, 3'b001, 1'b1, 2'd0};

    reset = 1; robReady = 0; flush = 0; uvalid = '0;
    for (int u = 0; u < 3; u++) begin
      uval[u] = 64'(100 + u); utag[u] = TW'(u + 1);
      ucmd[u] = 10'(16 * u + 3); uflg[u] = 4'(u + 8);
    end
    m_v = 0; m_val = '0; m_tag = '0; m_cmd = '0; m_flg = '0; m_unit = 0; m_last = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst; uvalid = vecs[i].uv; robReady = vecs[i].rr; flush = vecs[i].fl;
      mstep($sformatf("vec%0d", i), cg);
      chk($sformatf("vec%0d.tab_canGo", i), 64'(cg), 64'(vecs[i].exp_cg));
      chk($sformatf("vec%0d.tab_valid", i), 64'(cdbValid), 64'(vecs[i].exp_v));
      chk($sformatf("vec%0d.tab_unit", i), 64'(cdbUnit), 64'(vecs[i].exp_unit));
    end

    // Unit 2 result parked while the ROB stalls.
    reset = 1; uvalid = '0; robReady = 0; flush = 0;
    mstep("r36_rst", cg);
    reset = 0; uvalid = 3'b100; uval[2] = 64'd5; utag[2] = TW'(3); ucmd[2] = 10'd10;
    mstep("r36_grant", cg);
    chk("r36_pulse", 64'(cg), 64'(3'b100));
    uvalid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      mstep("r36_hold", cg);
      chk("r36_hold_cg", 64'(cg), 64'(0));
      chk("r36_hold_val", cdbVal, 64'd5);
      chk("r36_hold_tag", 64'(cdbTag), 64'd3);
    end
    uvalid = 3'b001;
    mstep("r36_stall_u0", cg);
    chk("r36_stall_cg", 64'(cg), 64'(0));

    // Back-to-back drain and load, no bubble.
    robReady = 1; uvalid = 3'b010; uval[1] = '1;
    mstep("r37", cg);
    chk("r37_cg", 64'(cg), 64'(3'b010));
    chk("r37_valid", 64'(cdbValid), 64'd1);
    chk("r37_val", cdbVal, {64{1'b1}});

    // Flush while full with unit 0 waiting.
    robReady = 0; uvalid = 3'b001; uval[0] = 64'h1234_5678_9abc_def0; flush = 1;
    mstep("r38_flush", cg);
    chk("r38_flush_cg", 64'(cg), 64'(0));
    chk("r38_flush_valid", 64'(cdbValid), 64'd0);
    flush = 0;
    mstep("r38_after", cg);
    chk("r38_after_cg", 64'(cg), 64'(3'b001));
    chk("r38_after_val", cdbVal, 64'h1234_5678_9abc_def0);

    // Reset while full with everyone requesting.
    uvalid = 3'b111; robReady = 1; reset = 1;
    mstep("r39_rst", cg);
    chk("r39_rst_cg", 64'(cg), 64'(0));
    chk("r39_zero", {63'(cdbVal | 64'(cdbTag) | 64'(cdbCmd) | 64'(cdbFlg) | 64'(cdbUnit)), cdbValid}, 64'd0);
    reset = 0;
    mstep("r39_rel", cg);
    chk("r39_rel_cg", 64'(cg), 64'(3'b001));

    // Single requester keeps winning every cycle.
    uvalid = 3'b010;
    for (int i = 0; i < 4; i++) begin
      mstep("r40", cg);
      chk("r40_cg", 64'(cg), 64'(3'b010));
    end

    // Randomized traffic; a unit keeps its request and payload until accepted.
    for (int u = 0; u < 3; u++) pend[u] = 0;
    reset = 0; flush = 0;
    for (int n = 0; n < 500; n++) begin
      for (int u = 0; u < 3; u++) begin
        if (!pend[u] && ($urandom_range(1) == 1)) begin
          pend[u] = 1;
          uval[u] = {$urandom, $urandom}; utag[u] = TW'($urandom);
          ucmd[u] = 10'($urandom); uflg[u] = 4'($urandom);
        end
        uvalid[u] = pend[u];
      end
      robReady = ($urandom_range(3) != 0);
      flush    = ($urandom_range(15) == 0);
      reset    = ($urandom_range(49) == 0);
      mstep("rand", cg);
      for (int u = 0; u < 3; u++) if (cg[u]) pend[u] = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_complete_arbiter.md
EXEC_COMPLETE_ARBITER -- requirements
Module: exec_complete_arbiter

Interface
REQ-001 Parameter: ROBsize, default 16, number of ROB entries.
REQ-002 Parameter: ROBsizeLog, default $clog2(ROBsize+1), tag width.
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_i  input  1  reset, synchronous and active-high.
REQ-005 Port: unitValid_i  input  3  per-unit result ready (bit 0 ALU, 1 multiplier, 2 divider); held until accepted.
REQ-006 Port: unit0Val_i / unit1Val_i / unit2Val_i  input  64 each  per-unit result value.
REQ-007 Port: unit0Tag_i / unit1Tag_i / unit2Tag_i  input  ROBsizeLog each  per-unit ROB tag.
REQ-008 Port: unit0Commands_i / unit1Commands_i / unit2Commands_i  input  10 each  per-unit command bits.
REQ-009 Port: unit0Flags_i / unit1Flags_i / unit2Flags_i  input  4 each  per-unit condition flags.
REQ-010 Port: canGo_o  output  3  one-hot accept pulse back to the granted unit.
REQ-011 Port: robReady_i  input  1  ROB/CDB consumer can take the registered result this cycle.
REQ-012 Port: flush_i  input  1  pipeline flush (mispredict); discards held result.
REQ-013 Port: cdbValid_o  output  1  registered result present.
REQ-014 Port: cdbVal_o  output  64  registered result value.
REQ-015 Port: cdbTag_o  output  ROBsizeLog  registered ROB tag.
REQ-016 Port: cdbCommands_o  output  10  registered command bits.
REQ-017 Port: cdbFlags_o  output  4  registered flags.
REQ-018 Port: cdbUnit_o  output  2  index (0-2) of unit that produced the registered result.

Function
REQ-019 Output stage is one register slot, states EMPTY (cdbValid_o=0) and FULL (cdbValid_o=1).
REQ-020 Slot can load (loadOk) when EMPTY, or when FULL and robReady_i=1 in the same cycle; loadOk=0 whenever flush_i=1.
REQ-021 Round-robin pointer last_r (2 bits, values 0-2) records last granted unit; search order is last_r+1, last_r+2, last_r+3 mod 3.
REQ-022 Grant = first unit in search order with unitValid_i set; canGo_o = one-hot grant AND loadOk, combinational, same cycle.
REQ-023 At most one canGo_o bit is high in any cycle; canGo_o=0 when no unit valid, loadOk=0, or flush_i=1.
REQ-024 On canGo_o pulse, next edge: slot loads granted unit's Val/Tag/Commands/Flags and index, cdbValid_o=1, last_r=granted index.
REQ-025 FULL with robReady_i=1 and no grant: next edge cdbValid_o=0; payload outputs hold prior values.
REQ-026 FULL with robReady_i=0: slot and payload hold unchanged; no grant issued.
REQ-027 Simultaneous drain and load (FULL, robReady_i=1, grant): next edge holds new result, cdbValid_o stays 1, giving one result per cycle throughput.
REQ-028 flush_i=1: next edge cdbValid_o=0 regardless of robReady_i; last_r unchanged; units remain unaccepted.
REQ-029 robReady_i is ignored while EMPTY.
REQ-030 Latency: unit valid to cdbValid_o is one cycle when slot is loadable.
REQ-031 last_r never takes value 3; if it does, it is treated as 2.

Reset
REQ-032 reset_i=1 at an edge: cdbValid_o=0, cdbVal_o=0, cdbTag_o=0, cdbCommands_o=0, cdbFlags_o=0, cdbUnit_o=0, last_r=2 (unit 0 highest priority first).
REQ-033 canGo_o=0 in every cycle reset_i=1; reset mid-operation drops the held result with no completion.
REQ-034 Reset has priority over flush_i, robReady_i and all grants.

Verification
REQ-035 After reset, unitValid_i=3'b111, robReady_i=1 held: canGo_o sequence 001,010,100,001 on consecutive cycles; cdbUnit_o follows 0,1,2 one cycle later.
REQ-036 Unit2 valid, Val=5, Tag=3, Commands=10, robReady_i=0: one canGo_o=100 pulse, then cdbValid_o=1, cdbVal_o=5, cdbTag_o=3 held, canGo_o=0 until robReady_i=1.
REQ-037 FULL, robReady_i=1, unit1 valid Val=0xFFFF_FFFF_FFFF_FFFF: same-cycle canGo_o=010; next cycle cdbValid_o=1, cdbVal_o=all ones, no empty bubble.
REQ-038 FULL with unit0 waiting, flush_i=1 one cycle: canGo_o=000 that cycle; next cycle cdbValid_o=0; following cycle canGo_o=001.
REQ-039 reset_i=1 while FULL and units valid: canGo_o=000; next cycle all cdb outputs 0; after release unit0 granted first.
REQ-040 Only unit1 valid for 4 cycles, robReady_i=1: canGo_o=010 every cycle; no pulse ever on a non-valid unit.
